method_client_02: RTL
=====================

METHOD_CLIENT_02 -- requirements
Module: method_client_02

Interface
REQ-001 SHALL have parameter W, default 6, operand, result and argument width.
REQ-002 SHALL have parameter CNT_W, default 8, transaction-count and counter width.
REQ-003 SHALL have parameter TIMEOUT, default 255, maximum cycles to wait for any one RDY.
REQ-004 SHALL provide CLK  in  1  sole clock, all state rising-edge.
REQ-005 SHALL provide RST_N  in  1  reset, asynchronous, active-low.
REQ-006 SHALL provide EN_go  in  1  host starts a run; honoured only while RDY_go=1.
REQ-007 SHALL provide go_count  in  CNT_W  transactions in the run.
REQ-008 SHALL provide go_seed  in  W  operand seed.
REQ-009 SHALL provide RDY_go  out  1  high in IDLE or DONE.
REQ-010 SHALL provide busy, done, timeout  out  1 each  run status flags.
REQ-011 SHALL provide pass_count, fail_count  out  CNT_W each  check tallies.
REQ-012 SHALL provide last_result  out  W  most recent captured result.
REQ-013 SHALL provide EN_start, EN_check  out  1 each  DUT action-method enables.
REQ-014 SHALL provide variable_a, variable_b, variable_c, variable_d  out  W each  DUT method arguments.
REQ-015 SHALL provide RDY_start, RDY_result, RDY_check  in  1 each  DUT method readies.
REQ-016 SHALL provide result  in  W  DUT value method; check  in  1  DUT actionvalue return (1 = pass).

Function
REQ-017 SHALL implement states IDLE, START, WAIT_RES, CHECK, DONE.
REQ-018 IDLE/DONE + EN_go: latch go_count and go_seed, clear index i, pass_count, fail_count and timeout, then go to START; if go_count=0, go to DONE instead.
REQ-019 In START: variable_a = i[W-1:0], variable_b = seed XOR i[W-1:0].
REQ-020 EN_start = (state==START) AND RDY_start, combinational, so it is never high without RDY_start.
REQ-021 A start firing moves the FSM to WAIT_RES next cycle.
REQ-022 In WAIT_RES: variable_c = (a+b) mod 2^W.
REQ-023 The first WAIT_RES cycle with RDY_result=1 captures result into last_result and moves to CHECK.
REQ-024 In CHECK: variable_d = last_result; EN_check = (state==CHECK) AND RDY_check.
REQ-025 On an EN_check firing: check=1 increments pass_count, check=0 increments fail_count; then i increments.
REQ-026 After a check firing, the FSM goes to START if i < count, else to DONE.
REQ-027 A wait counter SHALL clear on every state change and increment while START, WAIT_RES or CHECK is waiting.
REQ-028 When the wait counter reaches TIMEOUT: set timeout=1, go to DONE, and leave tallies unchanged.
REQ-029 Outside their states, variable_a/b/c/d SHALL be 0 and EN_start and EN_check SHALL be 0.
REQ-030 busy = state is START, WAIT_RES or CHECK; done = state is DONE.
REQ-031 EN_go while busy SHALL be ignored.
REQ-032 Tallies saturate at 2^CNT_W-1.

Reset
REQ-033 RST_N low SHALL asynchronously force IDLE, with i, tallies, wait counter, last_result and timeout all 0, and all status flags 0.
REQ-034 RST_N low mid-run SHALL abandon the run; EN_start and EN_check drop immediately.

Structure
REQ-035 The state enum and default widths SHALL live in shared package method_client_pkg.
REQ-036 The wait/timeout counter SHALL be sub-module mc_wait_timer; all other logic stays flat.

Verification
REQ-037 seed=6'h3F, count=4, all RDY=1, check=1 -> 4 start firings 3 cycles apart with a/b = 0/3F, 1/3E..., variable_c=3F, pass_count=4, done=1.
REQ-038 RDY_result held low 10 cycles -> FSM holds in WAIT_RES with no EN_check; result captured on cycle 11.
REQ-039 check alternates 1,0 over count=6 -> pass_count=3, fail_count=3.
REQ-040 RDY_start stuck low, TIMEOUT=5 -> timeout=1 and done=1 after 5 wait cycles, EN_start never high.
REQ-041 RST_N pulsed low during WAIT_RES -> IDLE on the same edge, outputs 0, RDY_go=1; a new run restarts with i=0.
REQ-042 count=0 -> DONE one cycle after EN_go with no DUT enables; EN_go while busy is ignored.

Source files
------------

// File: rtl/method_client_02_pkg.sv
// Shared state encoding and default sizing for the method_client_02 driver.
package method_client_pkg;
   localparam int W_DEF       = 6;
   localparam int CNT_W_DEF   = 8;
   localparam int TIMEOUT_DEF = 255;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_WAIT_RES,
      ST_CHECK,
      ST_DONE
   } mc_state_e;

   function automatic logic is_busy(input mc_state_e st);
      return (st == ST_START) || (st == ST_WAIT_RES) || (st == ST_CHECK);
   endfunction
endpackage

// File: rtl/method_client_02_if.sv
// Method-call bundle between the client (master) and the exercised DUT (slave).
interface method_client_02_if
   import method_client_pkg::*;
#(
   parameter int W = W_DEF
);
   logic         EN_start;
   logic         EN_check;
   logic [W-1:0] variable_a;
   logic [W-1:0] variable_b;
   logic [W-1:0] variable_c;
   logic [W-1:0] variable_d;
   logic         RDY_start;
   logic         RDY_result;
   logic         RDY_check;
   logic [W-1:0] result;
   logic         check;

   modport master (
      output EN_start, EN_check, variable_a, variable_b, variable_c, variable_d,
      input  RDY_start, RDY_result, RDY_check, result, check
   );

   modport slave (
      input  EN_start, EN_check, variable_a, variable_b, variable_c, variable_d,
      output RDY_start, RDY_result, RDY_check, result, check
   );
endinterface

// File: rtl/method_client_02_wait_timer.sv
// Counts cycles spent waiting on a DUT ready; flags expiry on the TIMEOUT-th wait cycle.
module mc_wait_timer
   import method_client_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic clear_i,
   input  logic inc_i,
   output logic expired_o
);
   localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

   logic [TW-1:0] cnt_q;
   logic [TW-1:0] cnt_inc;

   assign cnt_inc   = cnt_q + TW'(1);
   assign expired_o = inc_i && (cnt_inc >= TW'(TIMEOUT));

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else if (clear_i) begin
         cnt_q <= '0;
      end else if (inc_i) begin
         cnt_q <= cnt_inc;
      end
   end
endmodule

// File: rtl/method_client_02.sv
// Test-driver client: issues start/result/check method calls to a DUT for a
// programmed number of transactions and tallies pass/fail results.
module method_client_02
   import method_client_pkg::*;
#(
   parameter int W       = W_DEF,
   parameter int CNT_W   = CNT_W_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             EN_go,
   input  logic [CNT_W-1:0] go_count,
   input  logic [W-1:0]     go_seed,
   output logic             RDY_go,
   output logic             busy,
   output logic             done,
   output logic             timeout,
   output logic [CNT_W-1:0] pass_count,
   output logic [CNT_W-1:0] fail_count,
   output logic [W-1:0]     last_result,
   method_client_02_if.master mif
);
   mc_state_e        state_q, state_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [W-1:0]     seed_q, seed_d;
   logic [CNT_W-1:0] i_q, i_d;
   logic [CNT_W-1:0] pass_q, pass_d;
   logic [CNT_W-1:0] fail_q, fail_d;
   logic [W-1:0]     last_q, last_d;
   logic             timeout_q, timeout_d;

   logic [W-1:0]     a_w, b_w, sum_w;
   logic [CNT_W-1:0] i_inc;
   logic             progress, waiting, expired;

   assign a_w   = W'(i_q);
   assign b_w   = seed_q ^ a_w;
   assign sum_w = a_w + b_w;
   assign i_inc = i_q + CNT_W'(1);

   // Any method firing counts as progress; otherwise a busy cycle is a wait cycle.
   assign progress = ((state_q == ST_START)    && mif.RDY_start)  ||
                     ((state_q == ST_WAIT_RES) && mif.RDY_result) ||
                     ((state_q == ST_CHECK)    && mif.RDY_check);
   assign waiting  = is_busy(state_q) && !progress;

   mc_wait_timer #(
      .TIMEOUT(TIMEOUT)
   ) u_wait_timer (
      .clk_i    (CLK),
      .rst_ni   (RST_N),
      .clear_i  (state_d != state_q),
      .inc_i    (waiting),
      .expired_o(expired)
   );

   always_comb begin
      state_d        = state_q;
      count_d        = count_q;
      seed_d         = seed_q;
      i_d            = i_q;
      pass_d         = pass_q;
      fail_d         = fail_q;
      last_d         = last_q;
      timeout_d      = timeout_q;
      mif.EN_start   = 1'b0;
      mif.EN_check   = 1'b0;
      mif.variable_a = '0;
      mif.variable_b = '0;
      mif.variable_c = '0;
      mif.variable_d = '0;

      unique case (state_q)
         ST_IDLE, ST_DONE: begin
            if (EN_go) begin
               count_d   = go_count;
               seed_d    = go_seed;
               i_d       = '0;
               pass_d    = '0;
               fail_d    = '0;
               timeout_d = 1'b0;
               state_d   = (go_count == '0) ? ST_DONE : ST_START;
            end
         end
         ST_START: begin
            mif.variable_a = a_w;
            mif.variable_b = b_w;
            mif.EN_start   = mif.RDY_start;
            if (mif.RDY_start) begin
               state_d = ST_WAIT_RES;
            end else if (expired) begin
               timeout_d = 1'b1;
               state_d   = ST_DONE;
            end
         end
         ST_WAIT_RES: begin
            mif.variable_c = sum_w;
            if (mif.RDY_result) begin
               last_d  = mif.result;
               state_d = ST_CHECK;
            end else if (expired) begin
               timeout_d = 1'b1;
               state_d   = ST_DONE;
            end
         end
         ST_CHECK: begin
            mif.variable_d = last_q;
            mif.EN_check   = mif.RDY_check;
            if (mif.RDY_check) begin
               // Tallies stick at all-ones rather than wrapping.
               if (mif.check) begin
                  pass_d = (&pass_q) ? pass_q : pass_q + CNT_W'(1);
               end else begin
                  fail_d = (&fail_q) ? fail_q : fail_q + CNT_W'(1);
               end
               i_d     = i_inc;
               state_d = (i_inc < count_q) ? ST_START : ST_DONE;
            end else if (expired) begin
               timeout_d = 1'b1;
               state_d   = ST_DONE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q   <= ST_IDLE;
         count_q   <= '0;
         seed_q    <= '0;
         i_q       <= '0;
         pass_q    <= '0;
         fail_q    <= '0;
         last_q    <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         seed_q    <= seed_d;
         i_q       <= i_d;
         pass_q    <= pass_d;
         fail_q    <= fail_d;
         last_q    <= last_d;
         timeout_q <= timeout_d;
      end
   end

   assign RDY_go      = (state_q == ST_IDLE) || (state_q == ST_DONE);
   assign busy        = is_busy(state_q);
   assign done        = (state_q == ST_DONE);
   assign timeout     = timeout_q;
   assign pass_count  = pass_q;
   assign fail_count  = fail_q;
   assign last_result = last_q;
endmodule
